spi_slave_responder: RTL
========================

// Module: spi_slave_responder
// PURPOSE
//  SPI mode-0 slave (responder): the receiving end of the SPI link driven by the SCK divider.
//  Oversamples SCK/CSN/MOSI in the clk_50 domain, deserialises MOSI bytes and serialises MISO bytes.
//  Emulates nRF24L01 framing: status byte shifted out during the command byte, MSB first.
//  Used as the radio-side model in loopback/bring-up builds on the DE10-Lite.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth for SCK, CSN and MOSI (>=2)
//  DATA_W       8  bits per SPI byte
// PORTS
//  clk_50       in   1       system clock, 50 MHz
//  rst_n        in   1       asynchronous active-low reset
//  spi_sck      in   1       SPI clock from master, CPOL=0
//  spi_csn      in   1       chip select, active low
//  spi_mosi     in   1       master-out data
//  spi_miso     out  1       slave-out data (registered)
//  status_in    in   DATA_W  byte returned during first byte of each frame
//  tx_data      in   DATA_W  next response byte; sampled at load point
//  tx_req       out  1       1-cycle pulse: update tx_data for next byte
//  rx_data      out  DATA_W  last complete received byte
//  rx_valid     out  1       1-cycle pulse: rx_data updated
//  rx_first     out  1       valid with rx_valid: byte is the frame's command byte
//  busy         out  1       1 while a frame is active (state ACTIVE)
//  frame_err    out  1       only with SPI_RESP_FRAME_ERR_EN
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; sync chains reset to 0 (CSN low at release yields no fall edge).
//  Edge detect on last two sync stages; SCK half-period and CSN setup/hold >= 4 clk_50 cycles.
//  States: IDLE -> ACTIVE on synced CSN fall; ACTIVE -> IDLE on synced CSN rise.
//  CSN fall: tx_shift<=status_in, spi_miso<=status_in[7], bit_cnt<=0, first<=1, busy<=1.
//  SCK rise (ACTIVE): rx_shift<={rx_shift,mosi}; bit_cnt++ mod DATA_W.
//   On DATA_W-th rise: rx_data updated, rx_valid=1, rx_first=first, tx_req=1, first<=0, load_pend<=1.
//  SCK fall (ACTIVE): load_pend ? (tx_shift<=tx_data, miso<=tx_data[7]) : shift left, miso<=next bit.
//  tx_data must be stable from tx_req+2 cycles; sampled on the next detected SCK fall.
//  CSN rise: partial byte discarded (no rx_valid), miso<=0, busy<=0, load_pend<=0.
//  SCK edges in IDLE ignored; CSN edge and SCK edge in same cycle: CSN processed, SCK dropped.
//  Reset mid-frame: immediate IDLE; new frame needs CSN high then low.
//  Latency: pin edge to action = SYNC_STAGES+1 cycles.
// CONFIGURATION
//  SPI_RESP_FRAME_ERR_EN defined: frame_err pulses 1 cycle on CSN rise when bit_cnt!=0.
//  Not defined: no frame_err port, no related logic; partial bytes silently dropped.
// STRUCTURE
//  Package spi_pkg: SPI_BYTE_W, state encodings (ST_IDLE, ST_ACTIVE), MIN_HALF_PERIOD=4.
//  Sub-module spi_sync_edge: SYNC_STAGES sync + rise/fall pulses; one each for SCK, CSN (MOSI sync only).
// TESTING
//  1 Reset held, toggle pins -> all outputs 0, miso 0, busy 0.
//  2 SCK=clk_50/10, status_in=8'h0E, tx_data=8'hA5, MOSI 8'h61,8'h00 -> MISO 0E,A5; rx 61(first=1),00(first=0); 2 tx_req.
//  3 CSN rises after 5 bits -> no rx_valid; frame_err one pulse (macro on), absent (off); busy 0 after 3 cycles.
//  4 SCK toggling 16 edges with CSN high -> no rx_valid, no tx_req, miso 0.
//  5 rst_n low after 4 bits, released with CSN low -> stays IDLE; after CSN high/low, byte 8'h3C received.
//  6 Two frames, CSN high 4 cycles between, SCK half-period 4 cycles -> bytes 8'hFF,8'h01 correct, rx_first each.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI responder.
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int MIN_HALF_PERIOD = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for an asynchronous pin plus single-cycle rise/fall pulses.
// Edges are taken between the last sync stage and one extra history flop.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-1:0], d_i};
    end
  end

  assign rise_o =  chain_q[SYNC_STAGES-1] & ~chain_q[SYNC_STAGES];
  assign fall_o = ~chain_q[SYNC_STAGES-1] &  chain_q[SYNC_STAGES];

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder with nRF24L01-style framing (status byte shifted out first).
// Optional frame-error pulse on a short frame: define SPI_RESP_FRAME_ERR_EN.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = SPI_BYTE_W
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_csn,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] status_in,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_first,
  output logic              busy
`ifdef SPI_RESP_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int CNT_W = $clog2(DATA_W);

  logic sck_rise, sck_fall, csn_rise, csn_fall, mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              first_q, first_d;
  logic              load_pend_q, load_pend_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_first_q, rx_first_d;
  logic              tx_req_q, tx_req_d;
`ifdef SPI_RESP_FRAME_ERR_EN
  logic              frame_err_q, frame_err_d;
`endif

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk_i(clk_50), .rst_n_i(rst_n), .d_i(spi_sck), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csn_sync (
    .clk_i(clk_50), .rst_n_i(rst_n), .d_i(spi_csn), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  // MOSI shares the SCK delay so it lines up with the detected rising edge.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      first_q     <= 1'b0;
      load_pend_q <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
      tx_req_q    <= 1'b0;
`ifdef SPI_RESP_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      first_q     <= first_d;
      load_pend_q <= load_pend_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
      tx_req_q    <= tx_req_d;
`ifdef SPI_RESP_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    first_d     = first_q;
    load_pend_d = load_pend_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    rx_first_d  = 1'b0;
    tx_req_d    = 1'b0;
`ifdef SPI_RESP_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          state_d     = ST_ACTIVE;
          tx_shift_d  = status_in;
          miso_d      = status_in[DATA_W-1];
          bit_cnt_d   = '0;
          first_d     = 1'b1;
          load_pend_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        // CSN has priority; a coincident SCK edge is dropped.
        if (csn_rise) begin
          state_d     = ST_IDLE;
          miso_d      = 1'b0;
          load_pend_d = 1'b0;
          bit_cnt_d   = '0;
`ifdef SPI_RESP_FRAME_ERR_EN
          frame_err_d = (bit_cnt_q != '0);
`endif
        end else if (sck_rise) begin
          if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
            bit_cnt_d   = '0;
            rx_data_d   = {rx_shift_q, mosi_s};
            rx_valid_d  = 1'b1;
            rx_first_d  = first_q;
            tx_req_d    = 1'b1;
            first_d     = 1'b0;
            load_pend_d = 1'b1;
          end else begin
            bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          end
          rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
        end else if (sck_fall) begin
          if (load_pend_q) begin
            tx_shift_d  = tx_data;
            miso_d      = tx_data[DATA_W-1];
            load_pend_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], tx_shift_q[DATA_W-1]};
            miso_d     = tx_shift_q[DATA_W-2];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign spi_miso = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_first = rx_first_q;
  assign tx_req   = tx_req_q;
  assign busy     = (state_q == ST_ACTIVE);
`ifdef SPI_RESP_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule
